// File: rtl/sram_port_arbiter.sv
// Frame-buffer SRAM arbiter: scanout reads have priority, writes queue in a FIFO.
// Optional SRAM_ARB_STATS_EN adds saturating denied-read / issued-write counters.
module sram_port_arbiter #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 6,
  parameter int RD_LATENCY   = 1,
  parameter int WFIFO_DEPTH  = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              sramCLK,
  input  logic              reset,
  input  logic              rdReq,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic              rdGnt,
  output logic              rdValid,
  output logic [DATA_W-1:0] rdData,
  output logic              rdMiss,
  input  logic              wrValid,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  output logic              wrReady,
  output logic [ADDR_W-1:0] sramAddress,
  output logic [DATA_W-1:0] sramWrData,
  output logic              sramCE,
  output logic              sramWrEn,
`ifdef SRAM_ARB_STATS_EN
  output logic [15:0]       statRdMiss,
  output logic [15:0]       statWrites,
`endif
  input  logic [DATA_W-1:0] sramRdData
);

  localparam int FAW = $clog2(WFIFO_DEPTH);
  localparam int SCW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_READ,
    OP_WRITE
  } op_t;

  op_t                r_op;
  op_t                w_next;
  logic [ADDR_W-1:0]  r_fAddr [WFIFO_DEPTH];
  logic [DATA_W-1:0]  r_fData [WFIFO_DEPTH];
  logic [FAW-1:0]     r_wp;
  logic [FAW-1:0]     r_rp;
  logic [FAW:0]       r_cnt;
  logic [SCW-1:0]     r_starve;
  logic [RD_LATENCY-1:0] r_rdv;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_forceWr;
  logic w_doRd;
  logic w_doWr;

  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == (FAW+1)'(WFIFO_DEPTH));
  assign w_push    = wrValid && !w_full;
  assign wrReady   = !w_full;

  // A starved write steals the slot even while the reader is requesting.
  assign w_forceWr = (r_starve == SCW'(STARVE_LIMIT)) && !w_empty;
  assign w_doRd    = rdReq && !w_forceWr;
  assign w_doWr    = w_forceWr || (!rdReq && !w_empty);

  assign rdGnt   = w_doRd;
  assign rdData  = sramRdData;
  assign rdValid = r_rdv[RD_LATENCY-1];

  always_comb begin
    w_next = OP_IDLE;
    unique case (1'b1)
      w_doWr:  w_next = OP_WRITE;
      w_doRd:  w_next = OP_READ;
      default: w_next = OP_IDLE;
    endcase
  end

  always_ff @(posedge sramCLK) begin
    if (w_push) begin
      r_fAddr[r_wp] <= wrAddr;
      r_fData[r_wp] <= wrData;
    end
  end

  always_ff @(posedge sramCLK or posedge reset) begin
    if (reset) begin
      r_op        <= OP_IDLE;
      r_wp        <= '0;
      r_rp        <= '0;
      r_cnt       <= '0;
      r_starve    <= '0;
      r_rdv       <= '0;
      rdMiss      <= 1'b0;
      sramAddress <= '0;
      sramWrData  <= '0;
      sramCE      <= 1'b0;
      sramWrEn    <= 1'b0;
    end else begin
      r_op     <= w_next;
      sramCE   <= w_doRd || w_doWr;
      sramWrEn <= w_doWr;
      rdMiss   <= rdReq && w_forceWr;

      if (w_doWr) begin
        sramAddress <= r_fAddr[r_rp];
        sramWrData  <= r_fData[r_rp];
      end else if (w_doRd) begin
        sramAddress <= rdAddr;
      end

      if (w_empty || w_doWr)
        r_starve <= '0;
      else if (r_starve != SCW'(STARVE_LIMIT))
        r_starve <= r_starve + 1'b1;

      // r_op == READ marks the cycle the SRAM sees the read.
      r_rdv[0] <= (r_op == OP_READ);
      for (int i = 1; i < RD_LATENCY; i++)
        r_rdv[i] <= r_rdv[i-1];

      if (w_push)
        r_wp <= r_wp + 1'b1;
      if (w_doWr)
        r_rp <= r_rp + 1'b1;
      unique case ({w_push, w_doWr})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

`ifdef SRAM_ARB_STATS_EN
  always_ff @(posedge sramCLK or posedge reset) begin
    if (reset) begin
      statRdMiss <= '0;
      statWrites <= '0;
    end else begin
      if (rdReq && w_forceWr && statRdMiss != '1)
        statRdMiss <= statRdMiss + 1'b1;
      if (w_doWr && statWrites != '1)
        statWrites <= statWrites + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter with a 1-cycle SRAM model.
// Expected reads are queued at issue; a negedge monitor checks data and arrival cycle.
module tb_sram_port_arbiter;

  logic        sramCLK = 1'b0;
  logic        reset   = 1'b1;
  logic        rdReq   = 1'b0;
  logic [14:0] rdAddr  = '0;
  logic        wrValid = 1'b0;
  logic [14:0] wrAddr  = '0;
  logic [5:0]  wrData  = '0;
  logic        rdGnt;
  logic        rdValid;
  logic [5:0]  rdData;
  logic        rdMiss;
  logic        wrReady;
  logic [14:0] sramAddress;
  logic [5:0]  sramWrData;
  logic        sramCE;
  logic        sramWrEn;
  logic [5:0]  sramRdData;
`ifdef SRAM_ARB_STATS_EN
  logic [15:0] statRdMiss;
  logic [15:0] statWrites;
`endif

  sram_port_arbiter dut (
    .sramCLK     (sramCLK),
    .reset       (reset),
    .rdReq       (rdReq),
    .rdAddr      (rdAddr),
    .rdGnt       (rdGnt),
    .rdValid     (rdValid),
    .rdData      (rdData),
    .rdMiss      (rdMiss),
    .wrValid     (wrValid),
    .wrAddr      (wrAddr),
    .wrData      (wrData),
    .wrReady     (wrReady),
    .sramAddress (sramAddress),
    .sramWrData  (sramWrData),
    .sramCE      (sramCE),
    .sramWrEn    (sramWrEn),
`ifdef SRAM_ARB_STATS_EN
    .statRdMiss  (statRdMiss),
    .statWrites  (statWrites),
`endif
    .sramRdData  (sramRdData)
  );

  always #5 sramCLK = ~sramCLK;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge sramCLK) cyc <= cyc + 1;

  logic [5:0] mem [32768];
  logic [5:0] rdq = '0;
  assign sramRdData = rdq;

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = i[5:0];
  end

  always @(posedge sramCLK) begin
    if (sramCE && sramWrEn) mem[sramAddress] <= sramWrData;
    if (sramCE && !sramWrEn) rdq <= mem[sramAddress];
  end

  typedef struct {
    logic [5:0] d;
    int         c;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge sramCLK) begin
    exp_t e;
    if (rdValid === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rdValid: got unexpected data %0h expected none (cyc %0d)",
                 rdData, cyc);
      end else begin
        e = sb.pop_front();
        chk("rdData", 32'(rdData), 32'(e.d));
        chk("rdValid cycle", cyc, e.c);
      end
    end
  end

  task automatic step();
    @(posedge sramCLK);
    #1;
  endtask

  // One cycle of stimulus; returns 1ns after the next rising edge.
  task automatic cyc1(input logic rq, input logic [14:0] ra,
                      input logic eg, input logic [5:0] ed,
                      input logic wv, input logic [14:0] wa,
                      input logic [5:0] wd, input logic ewr);
    exp_t e;
    rdReq   = rq;
    rdAddr  = ra;
    wrValid = wv;
    wrAddr  = wa;
    wrData  = wd;
    @(negedge sramCLK);
    chk("rdGnt", 32'(rdGnt), 32'(eg));
    chk("wrReady", 32'(wrReady), 32'(ewr));
    if (eg) begin
      e.d = ed;
      e.c = cyc + 2;
      sb.push_back(e);
    end
    step();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " sramAddress"}, 32'(sramAddress), 0);
    chk({tag, " sramWrData"}, 32'(sramWrData), 0);
    chk({tag, " sramCE"}, 32'(sramCE), 0);
    chk({tag, " sramWrEn"}, 32'(sramWrEn), 0);
    chk({tag, " rdValid"}, 32'(rdValid), 0);
    chk({tag, " rdMiss"}, 32'(rdMiss), 0);
    chk({tag, " wrReady"}, 32'(wrReady), 1);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic f;
    int   wi;

    step();
    step();
    chk_zero("reset");
`ifdef SRAM_ARB_STATS_EN
    chk("reset statRdMiss", 32'(statRdMiss), 0);
    chk("reset statWrites", 32'(statWrites), 0);
`endif
    reset = 1'b0;
    step();

    // back-to-back reads 0..7
    for (int i = 0; i < 8; i++) begin
      cyc1(1'b1, 15'(i), 1'b1, 6'(i), 1'b0, 15'h0, 6'h0, 1'b1);
      chk("rd sramCE", 32'(sramCE), 1);
      chk("rd sramWrEn", 32'(sramWrEn), 0);
      chk("rd sramAddress", 32'(sramAddress), i);
      chk("rd rdMiss", 32'(rdMiss), 0);
    end
    repeat (3) cyc1(1'b0, 15'h0, 1'b0, 6'h0, 1'b0, 15'h0, 6'h0, 1'b1);

    // idle write latency
    cyc1(1'b0, 15'h0, 1'b0, 6'h0, 1'b1, 15'h1234, 6'h2A, 1'b1);
    chk("wr early sramCE", 32'(sramCE), 0);
    cyc1(1'b0, 15'h0, 1'b0, 6'h0, 1'b0, 15'h0, 6'h0, 1'b1);
    chk("wr sramCE", 32'(sramCE), 1);
    chk("wr sramWrEn", 32'(sramWrEn), 1);
    chk("wr sramAddress", 32'(sramAddress), 32'h1234);
    chk("wr sramWrData", 32'(sramWrData), 32'h2A);

    // fill the FIFO behind continuous reads
    for (int i = 0; i < 4; i++)
      cyc1(1'b1, 15'h7, 1'b1, 6'h7, 1'b1, 15'h200 + 15'(i),
           6'(i + 1), 1'b1);
    cyc1(1'b1, 15'h7, 1'b1, 6'h7, 1'b1, 15'h204, 6'h5, 1'b0);
    cyc1(1'b0, 15'h0, 1'b0, 6'h0, 1'b0, 15'h0, 6'h0, 1'b0);
    chk("drain0 sramAddress", 32'(sramAddress), 32'h200);
    chk("drain0 sramWrData", 32'(sramWrData), 1);
    for (int k = 1; k < 4; k++) begin
      cyc1(1'b0, 15'h0, 1'b0, 6'h0, 1'b0, 15'h0, 6'h0, 1'b1);
      chk("drain sramWrEn", 32'(sramWrEn), 1);
      chk("drain sramAddress", 32'(sramAddress), 32'h200 + k);
      chk("drain sramWrData", 32'(sramWrData), k + 1);
    end
    cyc1(1'b0, 15'h0, 1'b0, 6'h0, 1'b0, 15'h0, 6'h0, 1'b1);
    chk("drained sramCE", 32'(sramCE), 0);
    chk("idle holds sramAddress", 32'(sramAddress), 32'h203);

    // stale read, then re-read after the write drains
    cyc1(1'b1, 15'h100, 1'b1, 6'h00, 1'b1, 15'h100, 6'h15, 1'b1);
    cyc1(1'b1, 15'h100, 1'b1, 6'h00, 1'b0, 15'h0, 6'h0, 1'b1);
    cyc1(1'b0, 15'h0, 1'b0, 6'h0, 1'b0, 15'h0, 6'h0, 1'b1);
    cyc1(1'b1, 15'h100, 1'b1, 6'h15, 1'b0, 15'h0, 6'h0, 1'b1);
    repeat (3) cyc1(1'b0, 15'h0, 1'b0, 6'h0, 1'b0, 15'h0, 6'h0, 1'b1);

    // reset one cycle after a read grant, with a write queued
    rdReq   = 1'b1;
    rdAddr  = 15'h5;
    wrValid = 1'b1;
    wrAddr  = 15'h400;
    wrData  = 6'h3F;
    @(negedge sramCLK);
    chk("pre-reset rdGnt", 32'(rdGnt), 1);
    step();
    rdReq   = 1'b0;
    wrValid = 1'b0;
    reset   = 1'b1;
    #1;
    chk_zero("mid reset");
    step();
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc1(1'b0, 15'h0, 1'b0, 6'h0, 1'b0, 15'h0, 6'h0, 1'b1);
      chk("post-reset sramCE", 32'(sramCE), 0);
    end

    // starvation: 3 queued writes forced through continuous reads
    cyc1(1'b1, 15'h7, 1'b1, 6'h7, 1'b1, 15'h300, 6'h11, 1'b1);
    cyc1(1'b1, 15'h7, 1'b1, 6'h7, 1'b1, 15'h301, 6'h12, 1'b1);
    cyc1(1'b1, 15'h7, 1'b1, 6'h7, 1'b1, 15'h302, 6'h13, 1'b1);
    wi = 0;
    for (int k = 3; k <= 27; k++) begin
      f = (k == 9) || (k == 18) || (k == 27);
      cyc1(1'b1, 15'h7, !f, 6'h7, 1'b0, 15'h0, 6'h0, 1'b1);
      chk("starve rdMiss", 32'(rdMiss), 32'(f));
      if (f) begin
        chk("forced sramWrEn", 32'(sramWrEn), 1);
        chk("forced sramAddress", 32'(sramAddress), 32'h300 + wi);
        wi++;
      end
    end
    cyc1(1'b0, 15'h0, 1'b0, 6'h0, 1'b1, 15'h303, 6'h14, 1'b1);
    chk("after starve rdMiss", 32'(rdMiss), 0);
    cyc1(1'b0, 15'h0, 1'b0, 6'h0, 1'b1, 15'h304, 6'h15, 1'b1);
    chk("idle wr1 sramAddress", 32'(sramAddress), 32'h303);
    cyc1(1'b0, 15'h0, 1'b0, 6'h0, 1'b0, 15'h0, 6'h0, 1'b1);
    chk("idle wr2 sramAddress", 32'(sramAddress), 32'h304);
    chk("idle wr2 sramWrData", 32'(sramWrData), 32'h15);
    repeat (3) cyc1(1'b0, 15'h0, 1'b0, 6'h0, 1'b0, 15'h0, 6'h0, 1'b1);
`ifdef SRAM_ARB_STATS_EN
    chk("statRdMiss", 32'(statRdMiss), 3);
    chk("statWrites", 32'(statWrites), 5);
`endif

    chk("scoreboard pending", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
